pcileech_gbox_iobridge_peer: RTL and testbench

Bridge-side peer of the GBOX FPGA IO bridge bus. It is the far end of the 69-bit `BUS_DI` / `BUS_DI_PROG_FULL` / 37-bit `BUS_DO` link that the PCILeech communication core drives and samples.
- Downstream: it buffers incoming `BUS_DI` words and raises the programmable-full back-pressure flag, then delivers the words on a valid/ready stream.
- Upstream: it accepts words on a valid/ready stream and serialises them onto `BUS_DO`, one per cycle.

It is used on the bridge device and in the GBOX top-level bench as the link partner model.

---
 rtl/pcileech_gbox_iobridge_peer.sv | 126 ++++++++++++
 tb/tb_pcileech_gbox_iobridge_peer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_gbox_iobridge_peer.sv
// Far-end peer of the GBOX FPGA IO bridge link.
// Downstream: registers BUS_DI, buffers valid words in a FIFO and presents
// them first-word-fall-through on dn_*, with a registered prog-full flag
// that throttles the sender early enough to absorb words still in flight.
// Upstream: buffers up_* words and drives one per cycle onto BUS_DO.
module pcileech_gbox_iobridge_peer #(
  parameter int DI_DEPTH_LOG2   = 4,
  parameter int DI_PFULL_THRESH = 12,
  parameter int DO_DEPTH_LOG2   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [68:0]            BUS_DI,
  output logic                   BUS_DI_PROG_FULL,
  output logic [36:0]            BUS_DO,
  output logic [63:0]            dn_data,
  output logic [3:0]             dn_ctl,
  output logic                   dn_valid,
  input  logic                   dn_ready,
  input  logic [31:0]            up_data,
  input  logic [3:0]             up_ctl,
  input  logic                   up_valid,
  output logic                   up_ready,
  output logic                   di_overflow,
  output logic [DI_DEPTH_LOG2:0] di_count
);

  localparam int DI_DEPTH = 1 << DI_DEPTH_LOG2;
  localparam int DO_DEPTH = 1 << DO_DEPTH_LOG2;
  localparam int DI_CW    = DI_DEPTH_LOG2 + 1;
  localparam int DO_CW    = DO_DEPTH_LOG2 + 1;

  // ---------------- downstream ----------------
  logic [68:0]        di_q;
  logic [67:0]        di_mem [DI_DEPTH];
  logic [DI_CW-1:0]   di_wr_ptr;
  logic [DI_CW-1:0]   di_rd_ptr;
  logic [DI_CW-1:0]   di_count_next;
  logic               di_full;
  logic               di_empty;
  logic               di_wr_req;
  logic               di_wr_fire;
  logic               di_rd_fire;
  logic [67:0]        di_head;

  // The extra pointer MSB distinguishes full from empty when low bits match.
  assign di_full  = (di_wr_ptr[DI_DEPTH_LOG2] != di_rd_ptr[DI_DEPTH_LOG2]) &&
                    (di_wr_ptr[DI_DEPTH_LOG2-1:0] == di_rd_ptr[DI_DEPTH_LOG2-1:0]);
  assign di_empty = (di_wr_ptr == di_rd_ptr);
  assign di_count = di_wr_ptr - di_rd_ptr;

  assign dn_valid   = !di_empty;
  assign di_rd_fire = dn_valid && dn_ready;
  assign di_wr_req  = di_q[68];
  // A read in the same cycle frees the slot, so a write at full still lands.
  assign di_wr_fire = di_wr_req && (!di_full || di_rd_fire);

  assign di_count_next = di_count + DI_CW'(di_wr_fire) - DI_CW'(di_rd_fire);

  assign di_head = di_mem[di_rd_ptr[DI_DEPTH_LOG2-1:0]];
  assign dn_data = di_head[63:0];
  assign dn_ctl  = di_head[67:64];

  // Single input register stage on the incoming link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) di_q <= '0;
    else     di_q <= BUS_DI;
  end

  // Downstream storage array; contents are meaningless once pointers reset.
  always_ff @(posedge clk) begin
    if (di_wr_fire) di_mem[di_wr_ptr[DI_DEPTH_LOG2-1:0]] <= di_q[67:0];
  end

  // Downstream pointers, sticky overflow and registered prog-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      di_wr_ptr        <= '0;
      di_rd_ptr        <= '0;
      di_overflow      <= 1'b0;
      BUS_DI_PROG_FULL <= 1'b1;
    end else begin
      if (di_wr_fire) di_wr_ptr <= di_wr_ptr + DI_CW'(1);
      if (di_rd_fire) di_rd_ptr <= di_rd_ptr + DI_CW'(1);
      if (di_wr_req && di_full && !di_rd_fire) di_overflow <= 1'b1;
      BUS_DI_PROG_FULL <= (di_count_next >= DI_CW'(DI_PFULL_THRESH));
    end
  end

  // ---------------- upstream ----------------
  logic [35:0]        do_mem [DO_DEPTH];
  logic [DO_CW-1:0]   do_wr_ptr;
  logic [DO_CW-1:0]   do_rd_ptr;
  logic               do_full;
  logic               do_empty;
  logic               up_fire;

  assign do_full  = (do_wr_ptr[DO_DEPTH_LOG2] != do_rd_ptr[DO_DEPTH_LOG2]) &&
                    (do_wr_ptr[DO_DEPTH_LOG2-1:0] == do_rd_ptr[DO_DEPTH_LOG2-1:0]);
  assign do_empty = (do_wr_ptr == do_rd_ptr);
  assign up_ready = !do_full;
  assign up_fire  = up_valid && up_ready;

  // Upstream storage array.
  always_ff @(posedge clk) begin
    if (up_fire) do_mem[do_wr_ptr[DO_DEPTH_LOG2-1:0]] <= {up_ctl, up_data};
  end

  // BUS_DO has no back-pressure: pop the head every cycle it exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_wr_ptr <= '0;
      do_rd_ptr <= '0;
      BUS_DO    <= '0;
    end else begin
      if (up_fire) do_wr_ptr <= do_wr_ptr + DO_CW'(1);
      if (!do_empty) begin
        BUS_DO    <= {1'b1, do_mem[do_rd_ptr[DO_DEPTH_LOG2-1:0]]};
        do_rd_ptr <= do_rd_ptr + DO_CW'(1);
      end else begin
        BUS_DO    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcileech_gbox_iobridge_peer.sv
// Scoreboard bench for the GBOX IO bridge peer: expected words are queued
// as stimulus is driven and compared as the DUT emits them.
module tb_pcileech_gbox_iobridge_peer;

  logic        clk;
  logic        rst;
  logic [68:0] BUS_DI;
  logic        BUS_DI_PROG_FULL;
  logic [36:0] BUS_DO;
  logic [63:0] dn_data;
  logic [3:0]  dn_ctl;
  logic        dn_valid;
  logic        dn_ready;
  logic [31:0] up_data;
  logic [3:0]  up_ctl;
  logic        up_valid;
  logic        up_ready;
  logic        di_overflow;
  logic [4:0]  di_count;

  int checkCount;
  int failCount;

  logic [67:0] dnExp [$];
  logic [35:0] doExp [$];

  pcileech_gbox_iobridge_peer dut (
    .clk              (clk),
    .rst              (rst),
    .BUS_DI           (BUS_DI),
    .BUS_DI_PROG_FULL (BUS_DI_PROG_FULL),
    .BUS_DO           (BUS_DO),
    .dn_data          (dn_data),
    .dn_ctl           (dn_ctl),
    .dn_valid         (dn_valid),
    .dn_ready         (dn_ready),
    .up_data          (up_data),
    .up_ctl           (up_ctl),
    .up_valid         (up_valid),
    .up_ready         (up_ready),
    .di_overflow      (di_overflow),
    .di_count         (di_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [68:0] di, input logic uv,
                               input logic [3:0] uctl, input logic [31:0] udata);
    BUS_DI   = di;
    up_valid = uv;
    up_ctl   = uctl;
    up_data  = udata;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, 1'b0, 4'h0, 32'h0);
    dnExp.delete();
    doExp.delete();
    waitCycle();
    waitCycle();
    rst = 1'b0;
    waitCycle();
  endtask

  // Downstream scoreboard: the head seen at negedge is what the next edge pops
  always @(negedge clk) begin
    if (!rst && dn_valid && dn_ready) begin
      if (dnExp.size() > 0) checkOutput("dn_word", {dn_ctl, dn_data}, dnExp.pop_front());
      else                  checkOutput("dn_unexpected", 1, 0);
    end
  end

  // Upstream scoreboard on BUS_DO
  always @(negedge clk) begin
    if (!rst && BUS_DO[36]) begin
      if (doExp.size() > 0) checkOutput("do_word", BUS_DO[35:0], doExp.pop_front());
      else                  checkOutput("do_unexpected", 1, 0);
    end
  end

  initial begin
    logic [68:0] w;
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    dn_ready   = 1'b0;
    applyStimulus('0, 1'b0, 4'h0, 32'h0);

    // ---- reset / idle ----
    waitCycle();
    waitCycle();
    @(negedge clk);
    checkOutput("rst_pfull", BUS_DI_PROG_FULL, 1);
    checkOutput("rst_bus_do", BUS_DO, 0);
    checkOutput("rst_dn_valid", dn_valid, 0);
    checkOutput("rst_up_ready", up_ready, 1);
    checkOutput("rst_count", di_count, 0);
    checkOutput("rst_overflow", di_overflow, 0);
    waitCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("pfull_before_edge", BUS_DI_PROG_FULL, 1);
    waitCycle();
    @(negedge clk);
    checkOutput("pfull_after_edge", BUS_DI_PROG_FULL, 0);
    checkOutput("idle_bus_do", BUS_DO, 0);
    checkOutput("idle_dn_valid", dn_valid, 0);
    waitCycle();

    // ---- downstream stream with dn_ready=1 ----
    $display("[TB] downstream stream");
    dn_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = {1'b1, 4'(i), 64'hA5A5_0000_0000_0000 + 64'(i)};
      applyStimulus(w, 1'b0, 4'h0, 32'h0);
      dnExp.push_back(w[67:0]);
      @(negedge clk);
      if (i == 1) checkOutput("dn_latency_early", dn_valid, 0);
      if (i == 2) checkOutput("dn_latency", dn_valid, 1);
      waitCycle();
    end
    applyStimulus('0, 1'b0, 4'h0, 32'h0);
    repeat (5) waitCycle();
    checkOutput("dn_drained", dnExp.size(), 0);
    checkOutput("dn_overflow_clear", di_overflow, 0);
    checkOutput("dn_idle_valid", dn_valid, 0);

    // ---- prog-full and overflow ----
    $display("[TB] prog-full and overflow");
    dn_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      w = {1'b1, 4'(i), 64'hB000_0000_0000_0000 + 64'(i)};
      applyStimulus(w, 1'b0, 4'h0, 32'h0);
      if (i < 16) dnExp.push_back(w[67:0]);
      @(negedge clk);
      if (i == 12) begin
        checkOutput("count_11", di_count, 11);
        checkOutput("pfull_below", BUS_DI_PROG_FULL, 0);
      end
      if (i == 13) begin
        checkOutput("count_12", di_count, 12);
        checkOutput("pfull_at_thresh", BUS_DI_PROG_FULL, 1);
      end
      waitCycle();
    end
    applyStimulus('0, 1'b0, 4'h0, 32'h0);
    repeat (3) waitCycle();
    checkOutput("count_sat", di_count, 16);
    checkOutput("overflow_set", di_overflow, 1);
    checkOutput("pfull_full", BUS_DI_PROG_FULL, 1);
    dn_ready = 1'b1;
    repeat (20) waitCycle();
    checkOutput("ovf_drained", dnExp.size(), 0);
    checkOutput("ovf_dn_valid", dn_valid, 0);
    checkOutput("ovf_count", di_count, 0);
    checkOutput("ovf_sticky", di_overflow, 1);
    checkOutput("ovf_pfull_low", BUS_DI_PROG_FULL, 0);

    // ---- full with simultaneous read ----
    $display("[TB] full with simultaneous read");
    doReset();
    dn_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = {1'b1, 4'(15 - i), 64'hC0DE_0000_0000_0000 + 64'(i)};
      applyStimulus(w, 1'b0, 4'h0, 32'h0);
      dnExp.push_back(w[67:0]);
      waitCycle();
    end
    applyStimulus('0, 1'b0, 4'h0, 32'h0);
    repeat (3) waitCycle();
    checkOutput("full16", di_count, 16);
    checkOutput("full16_no_ovf", di_overflow, 0);
    w = {1'b1, 4'h9, 64'hDEAD_BEEF_0000_0042};
    applyStimulus(w, 1'b0, 4'h0, 32'h0);
    dnExp.push_back(w[67:0]);
    waitCycle();
    applyStimulus('0, 1'b0, 4'h0, 32'h0);
    dn_ready = 1'b1;
    waitCycle();
    @(negedge clk);
    checkOutput("full_rw_count", di_count, 16);
    checkOutput("full_rw_no_ovf", di_overflow, 0);
    repeat (20) waitCycle();
    checkOutput("full_rw_drained", dnExp.size(), 0);
    checkOutput("full_rw_no_ovf_end", di_overflow, 0);

    // ---- upstream burst ----
    $display("[TB] upstream burst");
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, 1'b1, 4'(i + 3), 32'h1000_0000 + 32'(i));
      doExp.push_back({4'(i + 3), 32'h1000_0000 + 32'(i)});
      @(negedge clk);
      checkOutput("up_ready", up_ready, 1);
      if (i == 1) checkOutput("do_latency_early", BUS_DO, 0);
      if (i >= 2) checkOutput("do_stream", BUS_DO[36], 1);
      waitCycle();
    end
    applyStimulus('0, 1'b0, 4'h0, 32'h0);
    repeat (4) waitCycle();
    checkOutput("do_drained", doExp.size(), 0);
    checkOutput("do_idle", BUS_DO, 0);

    // ---- reset mid-transfer ----
    $display("[TB] reset mid-transfer");
    dn_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus({1'b1, 4'(i), 64'hE000_0000_0000_0000 + 64'(i)}, 1'b1,
                    4'(i), 32'h2000_0000 + 32'(i));
      doExp.push_back({4'(i), 32'h2000_0000 + 32'(i)});
      waitCycle();
    end
    checkOutput("mid_count_nonzero", (di_count != 0), 1);
    #2;
    rst = 1'b1;
    applyStimulus('0, 1'b0, 4'h0, 32'h0);
    dnExp.delete();
    doExp.delete();
    #1;
    checkOutput("mid_rst_bus_do", BUS_DO, 0);
    checkOutput("mid_rst_dn_valid", dn_valid, 0);
    checkOutput("mid_rst_count", di_count, 0);
    checkOutput("mid_rst_pfull", BUS_DI_PROG_FULL, 1);
    checkOutput("mid_rst_up_ready", up_ready, 1);
    waitCycle();
    waitCycle();
    rst = 1'b0;
    dn_ready = 1'b1;
    repeat (10) waitCycle();
    checkOutput("post_rst_dn_valid", dn_valid, 0);
    checkOutput("post_rst_bus_do", BUS_DO, 0);
    checkOutput("post_rst_count", di_count, 0);
    checkOutput("post_rst_overflow", di_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
